// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and fills the IF/ID register.
// Flushes on redirect, holds on stall, and latches a sticky fault on a misaligned or out-of-range PC.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_0400,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0033
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   id_pc_q, id_pc_d;
  logic [XLEN-1:0]   id_pc4_q, id_pc4_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic              fault_q, fault_d;
  logic [XLEN-1:0]   fault_pc_q, fault_pc_d;
  logic              target_bad;

  assign target_bad = (redirect_target[1:0] != 2'b00) || (redirect_target >= ADDR_LIMIT);

  // Next-state and IF/ID update; everything holds unless a branch below changes it
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    instr_d    = instr_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;

    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (redirect_valid && target_bad) begin
          state_d    = FAULT;
          fault_d    = 1'b1;
          fault_pc_d = redirect_target;
          valid_d    = 1'b0;
          id_pc_d    = '0;
          id_pc4_d   = '0;
          instr_d    = NOP_INSTR;
        end else if (redirect_valid) begin
          pc_d     = redirect_target;
          valid_d  = 1'b0;
          id_pc_d  = '0;
          id_pc4_d = '0;
          instr_d  = NOP_INSTR;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (pc_q >= ADDR_LIMIT) begin
          state_d    = FAULT;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
          valid_d    = 1'b0;
          id_pc_d    = '0;
          id_pc4_d   = '0;
          instr_d    = NOP_INSTR;
        end else begin
          valid_d  = 1'b1;
          id_pc_d  = pc_q;
          id_pc4_d = pc_q + XLEN'(4);
          instr_d  = imem_instr;
          pc_d     = pc_q + XLEN'(4);
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      instr_q    <= NOP_INSTR;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      instr_q    <= instr_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_pc_plus4 = id_pc4_q;
  assign if_id_instr    = instr_q;
  assign fetch_fault    = fault_q;
  assign fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: vector table for the main stream, hand sequences for reset-from-fault and ROM-end fault.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  logic [31:0] rom [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < 32'h0000_0400) ? rom[imem_addr[9:2]] : 32'h0;

  if_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_instr     (if_id_instr),
    .fetch_fault     (fetch_fault),
    .fault_pc        (fault_pc)
  );

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rt;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        fault;
    logic [31:0] fpc;
    logic [31:0] addr;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'(v.valid));
    chk({tag, "_pc"},    if_id_pc,         v.pc);
    chk({tag, "_pc4"},   if_id_pc_plus4,   v.pc4);
    chk({tag, "_instr"}, if_id_instr,      v.instr);
    chk({tag, "_fault"}, 32'(fetch_fault), 32'(v.fault));
    chk({tag, "_fpc"},   fault_pc,         v.fpc);
    chk({tag, "_addr"},  imem_addr,        v.addr);
  endtask

  function automatic vec_t fetched(input logic s, input logic rv, input logic [31:0] rt,
                                   input logic [31:0] pc, input logic [31:0] addr);
    vec_t v;
    v = '{stall: s, rv: rv, rt: rt, valid: 1'b1, pc: pc, pc4: pc + 32'd4,
          instr: rom[pc[9:2]], fault: 1'b0, fpc: 32'h0, addr: addr};
    return v;
  endfunction

  function automatic vec_t bubble(input logic s, input logic rv, input logic [31:0] rt,
                                  input logic f, input logic [31:0] fpc, input logic [31:0] addr);
    vec_t v;
    v = '{stall: s, rv: rv, rt: rt, valid: 1'b0, pc: 32'h0, pc4: 32'h0,
          instr: NOP, fault: f, fpc: fpc, addr: addr};
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv0;
    bit   found;
    for (int i = 0; i < 256; i++) rom[i] = 32'hA500_0000 | 32'(i);
    rom[0]  = 32'h0000_12B7;
    rom[1]  = 32'h2342_8293;
    rom[2]  = 32'h0052_E333;
    rom[3]  = 32'h00A0_0393;
    rom[4]  = 32'h0072_8433;
    rom[13] = 32'h0000_66B3;
    rom[18] = 32'h0630_0793;

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rv0 = bubble(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk_all("reset", rv0);
    rst = 1'b0;

    // IDLE cycle, then first fetches
    vq.push_back(bubble(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0));
    vq.push_back(fetched(1'b0, 1'b0, 32'h0, 32'h00, 32'h04));
    vq.push_back(fetched(1'b0, 1'b0, 32'h0, 32'h04, 32'h08));
    vq.push_back(fetched(1'b0, 1'b0, 32'h0, 32'h08, 32'h0C));
    vq.push_back(fetched(1'b0, 1'b0, 32'h0, 32'h0C, 32'h10));
    // stall three cycles with pc = 0x10
    for (int i = 0; i < 3; i++) vq.push_back(fetched(1'b1, 1'b0, 32'h0, 32'h0C, 32'h10));
    for (int p = 32'h10; p <= 32'h2C; p += 4) vq.push_back(fetched(1'b0, 1'b0, 32'h0, 32'(p), 32'(p + 4)));
    // redirect to 0x34 while IF/ID holds 0x2C
    vq.push_back(bubble(1'b0, 1'b1, 32'h34, 1'b0, 32'h0, 32'h34));
    vq.push_back(fetched(1'b0, 1'b0, 32'h0, 32'h34, 32'h38));
    // redirect wins over stall
    vq.push_back(bubble(1'b1, 1'b1, 32'h48, 1'b0, 32'h0, 32'h48));
    vq.push_back(fetched(1'b0, 1'b0, 32'h0, 32'h48, 32'h4C));
    // misaligned target faults, then outputs freeze despite stall/redirect
    vq.push_back(bubble(1'b0, 1'b1, 32'h4E, 1'b1, 32'h4E, 32'h4C));
    for (int i = 0; i < 10; i++)
      vq.push_back(bubble(1'(i), 1'b1, 32'h100 + 32'(i * 4), 1'b1, 32'h4E, 32'h4C));

    foreach (vq[i]) begin
      stall = vq[i].stall;
      redirect_valid = vq[i].rv;
      redirect_target = vq[i].rt;
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), vq[i]);
    end

    // synchronous reset out of FAULT with stall and redirect asserted
    rst = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h8;
    @(posedge clk);
    #1;
    chk_all("rst_fault", rv0);
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;

    // sequential run to the end of the ROM
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk);
      #1;
      if (if_id_valid && if_id_pc == 32'h3FC) found = 1'b1;
    end
    chk("end_reach_3fc", 32'(found), 32'h1);
    chk("end_instr", if_id_instr, rom[255]);
    chk("end_pc4", if_id_pc_plus4, 32'h400);
    chk("end_nofault", 32'(fetch_fault), 32'h0);
    @(posedge clk);
    #1;
    chk("end_fault", 32'(fetch_fault), 32'h1);
    chk("end_fault_pc", fault_pc, 32'h400);
    chk("end_valid", 32'(if_id_valid), 32'h0);
    chk("end_instr_nop", if_id_instr, NOP);
    chk("end_addr", imem_addr, 32'h400);
    @(posedge clk);
    #1;
    chk("end_fault_hold", fault_pc, 32'h400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the pipelined RV32 core; the initiator side of the instruction ROM.
- Owns the PC register and drives the ROM word address.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, branch/jump redirect with wrong-path flush, and fetch faults (misaligned or out-of-range PC).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_LIMIT, 32'h0000_0400, first byte address past the 1 KB instruction ROM; any PC >= this faults.
- NOP_INSTR, 32'h0000_0033, bubble encoding (ADD x0,x0,x0) written into IF/ID when invalid.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to instruction ROM; always equals the current PC; ROM returns the word combinationally in the same cycle.
- imem_instr  in  32  instruction word from ROM for imem_addr.
- stall  in  1  hold request from hazard unit (load-use).
- redirect_valid  in  1  taken branch / JAL / JALR resolved downstream.
- redirect_target  in  32  new PC when redirect_valid=1.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  32  PC of the IF/ID instruction.
- if_id_pc_plus4  out  32  if_id_pc + 4 (link value for JAL/JALR).
- if_id_instr  out  32  fetched instruction, or NOP_INSTR when invalid.
- fetch_fault  out  1  sticky fault flag.
- fault_pc  out  32  offending address latched on fault entry.

Behaviour:
- All state updates on the rising clk edge; rst sampled synchronously and overrides everything, including mid-stall, mid-redirect and FAULT.
- Reset values:
  - pc = RESET_PC; state = IDLE.
  - if_id_valid = 0; if_id_pc = 0; if_id_pc_plus4 = 0; if_id_instr = NOP_INSTR.
  - fetch_fault = 0; fault_pc = 0.
- imem_addr is a combinational copy of pc; no other path to it.
- States: IDLE, RUN, FAULT.
- IDLE: exactly one cycle after rst deasserts.
  - pc holds; IF/ID stays a bubble; stall and redirect are ignored.
  - Next state RUN.
- RUN, evaluated in priority order:
  1. redirect_valid=1, and (redirect_target[1:0] != 0 or redirect_target >= ADDR_LIMIT):
     - Go to FAULT; fault_pc = redirect_target; fetch_fault = 1.
     - IF/ID becomes a bubble; pc unchanged.
  2. redirect_valid=1 with a legal target:
     - pc = redirect_target.
     - IF/ID becomes a bubble, flushing the wrong-path instruction.
     - Redirect wins over a simultaneous stall.
  3. stall=1: pc and all IF/ID outputs hold their values.
  4. pc >= ADDR_LIMIT (reached by sequential increment):
     - Go to FAULT; fault_pc = pc; IF/ID becomes a bubble.
  5. Otherwise, normal fetch:
     - if_id_valid = 1; if_id_pc = pc; if_id_pc_plus4 = pc + 4; if_id_instr = imem_instr.
     - pc = pc + 4.
- Bubble means: valid = 0, instr = NOP_INSTR, pc fields = 0.
- Arithmetic: pc + 4 is 32-bit, modulo 2^32; wrap-around is not possible below ADDR_LIMIT.
- FAULT:
  - pc frozen; IF/ID held as a bubble; fetch_fault = 1; fault_pc stable.
  - stall and redirect are ignored; only rst exits.
- Latency: an instruction at PC p appears on if_id_* one cycle after pc = p, given no stall or redirect. One bubble follows each redirect.
- Ports and regs must not be driven with X after reset.

Test Plan:
- rst high for 2 cycles, then low, with the ROM program loaded.
  - Cycle 1 (IDLE): if_id_valid = 0.
  - Following cycles: if_id_pc = 0x0, 0x4, 0x8 with if_id_instr = 0x000012B7, 0x23428293, 0x0052E333.
- Stall high for 3 cycles while pc = 0x10:
  - IF/ID holds pc 0xC / instr 0x00A00393 for 3 cycles.
  - Then pc 0x10 / instr 0x00728433.
- Redirect in the cycle IF/ID holds 0x2C (target 0x34):
  - Next IF/ID: valid = 0, instr = 0x00000033.
  - Then pc 0x34, instr 0x000066B3, pc_plus4 0x38.
- redirect_valid = 1 and stall = 1 together with target 0x48:
  - Redirect taken: bubble, then pc 0x48, instr 0x06300793.
- Redirect target 0x4E (misaligned):
  - fetch_fault = 1 and fault_pc = 0x4E next cycle.
  - Outputs stay frozen for 10 cycles despite further redirects.
  - rst clears all to reset values.
- Sequential run through 0x3FC:
  - 0x3FC is captured with valid = 1.
  - Next cycle: fetch_fault = 1, fault_pc = 0x400, if_id_valid = 0.
